// File: rtl/gba_frame_capture_pkg.sv
// gba_frame_capture_pkg: frame geometry, pixel width and capture FSM states shared with scan-out
package gba_frame_capture_pkg;
  localparam int unsigned H_ACTIVE = 240;
  localparam int unsigned V_ACTIVE = 160;
  localparam int unsigned PIX_W = 15;
  localparam int unsigned FB_DEPTH = H_ACTIVE * V_ACTIVE;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } cap_state_t;
endpackage

// File: rtl/gba_fb_ram.sv
// gba_fb_ram: two-bank simple dual-port frame RAM, one write port, one registered read port
module gba_fb_ram
  import gba_frame_capture_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH,
  parameter int unsigned W = PIX_W
) (
  input  logic         clk,
  input  logic         we,
  input  logic         wr_bank,
  input  logic [15:0]  wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic         rd_bank,
  input  logic [15:0]  rd_addr,
  output logic [W-1:0] rd_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [W-1:0] mem [2][DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr[AW-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_addr[AW-1:0]];
  end
endmodule

// File: rtl/gba_frame_capture.sv
// gba_frame_capture: double-buffered GBA frame store, raster capture into back bank, tear-free swap at display frame start
module gba_frame_capture
  import gba_frame_capture_pkg::*;
#(
  parameter int unsigned LINE_PIX = H_ACTIVE,
  parameter int unsigned FRAME_LINES = V_ACTIVE
) (
  input  logic             i_clock50,
  input  logic             i_reset,
  input  logic             i_frame_start,
  input  logic             i_px_valid,
  input  logic [PIX_W-1:0] i_px_data,
  input  logic             i_disp_vstart,
  input  logic [15:0]      i_rdaddr,
  output logic [PIX_W-1:0] o_RGB,
  output logic             o_front_bank,
  output logic             o_frame_ready,
  output logic [7:0]       o_drop_count
);
  localparam int unsigned DEPTH = LINE_PIX * FRAME_LINES;
  localparam logic [15:0] LAST = 16'(DEPTH - 1);
  localparam logic [15:0] LIMIT = 16'(DEPTH);
  cap_state_t state, state_n;
  logic [15:0] wr_addr, wr_addr_n, wr_ptr;
  logic front_n, ready_n, we, rd_ok, rd_ok_q;
  logic [7:0] drop_n, drop_inc;
  logic [PIX_W-1:0] rd_data;
  assign drop_inc = o_drop_count + 8'(o_drop_count != 8'hFF);
  assign rd_ok = i_rdaddr < LIMIT;
  assign o_RGB = rd_ok_q ? rd_data : '0;
  always_ff @(posedge i_clock50) begin
    if (i_reset) begin
      state <= IDLE;
      wr_addr <= '0;
      o_front_bank <= 1'b0;
      o_frame_ready <= 1'b0;
      o_drop_count <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      state <= state_n;
      wr_addr <= wr_addr_n;
      o_front_bank <= front_n;
      o_frame_ready <= ready_n;
      o_drop_count <= drop_n;
      rd_ok_q <= rd_ok;
    end
  end
  always_comb begin
    state_n = state;
    wr_addr_n = wr_addr;
    wr_ptr = wr_addr;
    front_n = o_front_bank;
    ready_n = o_frame_ready;
    drop_n = o_drop_count;
    we = 1'b0;
    case (state)
      IDLE: begin
        state_n = i_frame_start ? CAPTURE : IDLE;
        wr_addr_n = i_frame_start ? '0 : wr_addr;
      end
      CAPTURE: begin
        // a restart and a pixel in the same cycle put that pixel at address 0
        wr_ptr = i_frame_start ? '0 : wr_addr;
        drop_n = i_frame_start ? drop_inc : o_drop_count;
        we = i_px_valid;
        wr_addr_n = i_px_valid ? wr_ptr + 16'd1 : wr_ptr;
        if (i_px_valid && wr_ptr == LAST) begin
          state_n = FULL;
          ready_n = 1'b1;
        end
      end
      FULL: begin
        if (i_disp_vstart && o_frame_ready) begin
          front_n = !o_front_bank;
          ready_n = 1'b0;
          wr_addr_n = '0;
          state_n = i_frame_start ? CAPTURE : IDLE;
        end else if (i_frame_start) begin
          drop_n = drop_inc;
          ready_n = 1'b0;
          wr_addr_n = '0;
          state_n = CAPTURE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  gba_fb_ram #(.DEPTH(DEPTH), .W(PIX_W)) u_ram (
    .clk     (i_clock50),
    .we      (we),
    .wr_bank (!o_front_bank),
    .wr_addr (wr_ptr),
    .wr_data (i_px_data),
    .rd_en   (rd_ok),
    .rd_bank (o_front_bank),
    .rd_addr (i_rdaddr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_gba_frame_capture.sv
// tb_gba_frame_capture: directed+random stimulus checked against a frame-level reference model
module tb_gba_frame_capture;
  localparam int LP = 32;
  localparam int FL = 20;
  localparam int D = LP * FL;
  logic clk = 0, rst = 1, fs = 0, pv = 0, vs = 0;
  logic [14:0] pd = 0;
  logic [15:0] ra = 0;
  logic [14:0] rgb;
  logic fb, rdy;
  logic [7:0] drop;
  int tests = 0, fails = 0;
  logic [14:0] mm [2][D];
  bit mk [2][D];
  bit m_front = 0, m_ready = 0;
  int m_drop = 0, m_cnt = -1;
  always #10 clk = ~clk;
  gba_frame_capture #(.LINE_PIX(LP), .FRAME_LINES(FL)) dut (
    .i_clock50     (clk),
    .i_reset       (rst),
    .i_frame_start (fs),
    .i_px_valid    (pv),
    .i_px_data     (pd),
    .i_disp_vstart (vs),
    .i_rdaddr      (ra),
    .o_RGB         (rgb),
    .o_front_bank  (fb),
    .o_frame_ready (rdy),
    .o_drop_count  (drop)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, D + 1));
  endfunction
  task automatic cyc(bit f, bit p, logic [14:0] d, bit v, logic [15:0] a);
    bit known;
    logic [14:0] exp_rgb;
    fs = f; pv = p; pd = d; vs = v; ra = a;
    known = 1;
    exp_rgb = 0;
    if (int'(a) < D) begin
      known = mk[m_front][a];
      exp_rgb = mm[m_front][a];
    end
    if (m_ready && v) begin
      m_front = !m_front;
      m_ready = 0;
      m_cnt = f ? 0 : -1;
    end else if (m_cnt < 0) begin
      if (f) m_cnt = 0;
    end else if (m_cnt == D) begin
      if (f) begin
        m_drop = m_drop < 255 ? m_drop + 1 : 255;
        m_ready = 0;
        m_cnt = 0;
      end
    end else begin
      if (f) begin
        m_drop = m_drop < 255 ? m_drop + 1 : 255;
        m_cnt = 0;
      end
      if (p) begin
        mm[!m_front][m_cnt] = d;
        mk[!m_front][m_cnt] = 1;
        m_cnt++;
        if (m_cnt == D) m_ready = 1;
      end
    end
    @(posedge clk);
    #1;
    fs = 0; pv = 0; vs = 0;
    check("front", fb, m_front);
    check("ready", rdy, m_ready);
    check("drop", drop, m_drop);
    if (known) check("rgb", rgb, exp_rgb);
  endtask
  task automatic pixels(int n, int kind, bit gaps);
    logic [14:0] v;
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, rnd_addr());
      v = kind == 0 ? 15'(i) : kind == 1 ? 15'h7C00 : kind == 3 ? 15'h5555 : 15'($urandom);
      cyc(0, 1, v, 0, rnd_addr());
    end
  endtask
  task automatic rd(string tag, logic [15:0] a, logic [14:0] exp);
    cyc(0, 0, 0, 0, a);
    check(tag, rgb, exp);
  endtask
  task automatic do_reset(bit p);
    rst = 1; fs = 0; vs = 0; pv = p; pd = 15'($urandom);
    ra = 16'($urandom_range(0, D - 1));
    @(posedge clk);
    #1;
    rst = 0; pv = 0;
    m_front = 0; m_ready = 0; m_drop = 0; m_cnt = -1;
    check("rst_front", fb, 0);
    check("rst_ready", rdy, 0);
    check("rst_drop", drop, 0);
    check("rst_rgb", rgb, 0);
  endtask
  initial begin
    do_reset(0);
    cyc(1, 0, 0, 0, 0);
    pixels(D, 0, 0);
    check("t1_ready", rdy, 1);
    cyc(0, 0, 0, 1, 0);
    check("t1_front", fb, 1);
    check("t1_ready_clr", rdy, 0);
    rd("t1_rd0", 0, 0);
    rd("t1_rd_line", 16'(LP - 1), 15'(LP - 1));
    rd("t1_rd_last", 16'(D - 1), 15'(D - 1));
    cyc(1, 0, 0, 0, 0);
    pixels(D, 1, 1);
    rd("t2_old", 7, 7);
    cyc(0, 0, 0, 1, 0);
    check("t2_front", fb, 0);
    rd("t2_new", 7, 15'h7C00);
    rd("t2_new_last", 16'(D - 1), 15'h7C00);
    cyc(1, 0, 0, 0, 0);
    pixels(100, 2, 0);
    cyc(1, 0, 0, 0, 0);
    check("t3_drop", drop, 1);
    pixels(D, 2, 1);
    cyc(0, 0, 0, 1, 0);
    check("t3_front", fb, 1);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 0, rnd_addr());
    cyc(1, 0, 0, 0, 0);
    pixels(D, 0, 0);
    check("t4_ready", rdy, 1);
    pixels(5, 3, 0);
    cyc(1, 0, 0, 1, 0);
    check("t4_front", fb, 0);
    check("t4_ready_clr", rdy, 0);
    check("t4_drop", drop, 1);
    rd("t4_rd0", 0, 0);
    rd("t4_rd_last", 16'(D - 1), 15'(D - 1));
    pixels(D, 2, 1);
    check("t4_next_ready", rdy, 1);
    cyc(0, 0, 0, 1, 0);
    check("t4_next_front", fb, 1);
    rd("t5_oob_depth", 16'(D), 0);
    rd("t5_oob_max", 16'hFFFF, 0);
    for (int i = 0; i < 300; i++) begin
      cyc(1, 0, 0, 0, rnd_addr());
      pixels($urandom_range(0, 3), 2, 0);
    end
    check("t5_drop_sat", drop, 255);
    cyc(1, 0, 0, 0, 0);
    pixels(D / 2, 2, 0);
    do_reset(1);
    cyc(1, 0, 0, 0, 0);
    pixels(D, 0, 1);
    cyc(0, 0, 0, 1, 0);
    check("t6_front", fb, 1);
    rd("t6_rd_line", 16'(LP - 1), 15'(LP - 1));
    rd("t6_rd_last", 16'(D - 1), 15'(D - 1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
